// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch front end: next-PC select encodings and fetch FSM states.
// The PC_OP_LEN macro is kept for older files that size pc_op with it.
`ifndef PC_OP_LEN
`define PC_OP_LEN 3
`endif

package pc_fetch_unit_pkg;

  localparam int PC_OP_LEN = `PC_OP_LEN;

  localparam logic [PC_OP_LEN-1:0] PC_OP_NEXT_STEP  = PC_OP_LEN'(0);
  localparam logic [PC_OP_LEN-1:0] PC_OP_OFFSET_JMP = PC_OP_LEN'(1);
  localparam logic [PC_OP_LEN-1:0] PC_OP_IMM_JMP    = PC_OP_LEN'(2);
  localparam logic [PC_OP_LEN-1:0] PC_OP_REG_JMP    = PC_OP_LEN'(3);

  typedef enum logic [1:0] {
    FETCH_ST_BOOT  = 2'd0,
    FETCH_ST_FETCH = 2'd1,
    FETCH_ST_HOLD  = 2'd2,
    FETCH_ST_ERR   = 2'd3
  } fetch_st_e;

  // Branch displacement is a signed word count; turn it into a byte offset.
  function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc.sv
// Combinational next-PC selection used at instruction retire.
// A misaligned register target is flagged so the caller can keep the PC unchanged.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0]          pc,
  input  logic [25:0]          inst_index,
  input  logic [PC_OP_LEN-1:0] pc_op,
  input  logic [31:0]          reg_target,
  output logic [31:0]          npc,
  output logic                 misalign
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    npc      = pc_plus4;
    misalign = 1'b0;
    case (pc_op)
      PC_OP_OFFSET_JMP: npc = pc_plus4 + sext_word_offset(inst_index[15:0]);
      PC_OP_IMM_JMP:    npc = {pc_plus4[31:28], inst_index, 2'b00};
      PC_OP_REG_JMP: begin
        npc      = reg_target;
        misalign = |reg_target[1:0];
      end
      default:          npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Non-pipelined instruction fetch front end: holds the PC, fetches one word per
// instruction over a req/rvalid port and presents the decoded fields until retire.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_OP_LEN-1:0] pc_op,
  input  logic [31:0]          reg_target,
  input  logic                 inst_done,
  input  logic                 stall,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [5:0]           inst_op,
  output logic [5:0]           instR_func,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  fetch_st_e        state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      npc;
  logic             misalign;
  logic             resp_accept;
  logic             tmo_hit;
  logic             retire_ok;
  logic             retire_bad;

  next_pc_calc u_next_pc (
    .pc         (pc),
    .inst_index (inst[25:0]),
    .pc_op      (pc_op),
    .reg_target (reg_target),
    .npc        (npc),
    .misalign   (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_ST_BOOT;
    else     state <= state_next;
  end

  // BOOT lasts one cycle so a response left over from before reset is never latched.
  always_comb begin
    state_next  = state;
    resp_accept = 1'b0;
    tmo_hit     = 1'b0;
    retire_ok   = 1'b0;
    retire_bad  = 1'b0;
    case (state)
      FETCH_ST_BOOT: state_next = FETCH_ST_FETCH;
      FETCH_ST_FETCH: begin
        if (imem_rvalid) begin
          resp_accept = 1'b1;
          state_next  = FETCH_ST_HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = FETCH_ST_ERR;
        end
      end
      FETCH_ST_HOLD: begin
        if (inst_done && !stall) begin
          if (misalign) begin
            retire_bad = 1'b1;
            state_next = FETCH_ST_ERR;
          end else begin
            retire_ok  = 1'b1;
            state_next = FETCH_ST_FETCH;
          end
        end
      end
      FETCH_ST_ERR:  state_next = FETCH_ST_ERR;
      default:       state_next = FETCH_ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req   = (state == FETCH_ST_FETCH);
    inst_valid = (state == FETCH_ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (resp_accept) inst <= imem_rdata;
      if (retire_ok)   pc   <= npc;
      if (tmo_hit || retire_bad) fetch_err <= 1'b1;
      if (state == FETCH_ST_FETCH && !resp_accept && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                                                     tmo_cnt <= '0;
    end
  end

  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign inst_op    = inst[31:26];
  assign instR_func = inst[5:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario bench for pc_fetch_unit: expected fetch addresses and instruction words are
// queued when stimulus is driven and compared when the DUT requests or presents them.
module tb_pc_fetch_unit
  import pc_fetch_unit_pkg::*;
;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [PC_OP_LEN-1:0] pc_op;
  logic [31:0]          reg_target;
  logic                 inst_done;
  logic                 stall;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_rvalid;
  logic [31:0]          imem_rdata;
  logic                 inst_valid;
  logic [31:0]          inst;
  logic [5:0]           inst_op;
  logic [5:0]           instR_func;
  logic [31:0]          pc;
  logic [31:0]          pc_plus4;
  logic                 fetch_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  typedef struct packed {
    logic [PC_OP_LEN-1:0] op;
    logic [31:0]          tgt;
    logic [31:0]          nxt;
    logic [31:0]          data;
  } step_t;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_op       (pc_op),
    .reg_target  (reg_target),
    .inst_done   (inst_done),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_op     (inst_op),
    .instR_func  (instR_func),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic respond(input logic [31:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic retire(input logic [PC_OP_LEN-1:0] op, input logic [31:0] tgt);
    pc_op      = op;
    reg_target = tgt;
    inst_done  = 1'b1;
    step();
    inst_done  = 1'b0;
    pc_op      = PC_OP_NEXT_STEP;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    do_reset();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || fetch_err !== 1'b0 ||
        pc !== 32'h0 || pc_plus4 !== 32'h4 || inst_op !== 6'h0 || instR_func !== 6'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: req=%b valid=%b inst=%h err=%b pc=%h pc4=%h op=%h fn=%h, expected 0/0/0/0/0/4/0/0",
               imem_req, inst_valid, inst, fetch_err, pc, pc_plus4, inst_op, instR_func);
    end
    exp_addr_q.push_back(32'h0);
    step();
    e = exp_addr_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== e) begin
      errors++;
      $display("[TB] FAIL boot_fetch: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, e);
    end
    exp_inst_q.push_back(32'h2008_0005);
    respond(32'h2008_0005);
    e = exp_inst_q.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== e || inst_op !== e[31:26] || instR_func !== e[5:0] || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_inst: valid=%b inst=%h op=%h fn=%h req=%b, expected valid=1 inst=%h op=%h fn=%h req=0",
               inst_valid, inst, inst_op, instR_func, imem_req, e, e[31:26], e[5:0]);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    bit ok;
    for (int i = 1; i <= 3; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      retire(PC_OP_NEXT_STEP, 32'h0);
      wait_req(ok);
      e = exp_addr_q.pop_front();
      checks++;
      if (!ok || imem_addr !== e || pc_plus4 !== e + 32'd4) begin
        errors++;
        $display("[TB] FAIL seq_step%0d: req=%b addr=%h pc4=%h, expected addr=%h pc4=%h",
                 i, imem_req, imem_addr, pc_plus4, e, e + 32'd4);
      end
      respond(32'h0);
    end
  endtask

  task automatic test_branch();
    step_t tbl [5];
    logic [31:0] e;
    bit ok;
    tbl[0] = '{PC_OP_NEXT_STEP,  32'h0, 32'h0000_0010, 32'h1000_FFFE};
    tbl[1] = '{PC_OP_OFFSET_JMP, 32'h0, 32'h0000_000C, 32'h0000_0000};
    tbl[2] = '{PC_OP_NEXT_STEP,  32'h0, 32'h0000_0010, 32'h1000_0003};
    tbl[3] = '{PC_OP_OFFSET_JMP, 32'h0, 32'h0000_0020, 32'h1000_FFFE};
    tbl[4] = '{PC_OP_LEN'(5),    32'h0, 32'h0000_0024, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      exp_addr_q.push_back(tbl[i].nxt);
      retire(tbl[i].op, tbl[i].tgt);
      wait_req(ok);
      e = exp_addr_q.pop_front();
      checks++;
      if (!ok || imem_addr !== e) begin
        errors++;
        $display("[TB] FAIL branch%0d: req=%b addr=%h, expected %h", i, imem_req, imem_addr, e);
      end
      respond(tbl[i].data);
    end
  endtask

  task automatic test_jumps();
    step_t tbl [5];
    logic [31:0] e;
    bit ok;
    tbl[0] = '{PC_OP_REG_JMP,   32'hF000_0000, 32'hF000_0000, 32'h0800_0040};
    tbl[1] = '{PC_OP_IMM_JMP,   32'h0,         32'hF000_0100, 32'h0000_0000};
    tbl[2] = '{PC_OP_REG_JMP,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1000_0001};
    tbl[3] = '{PC_OP_NEXT_STEP, 32'h0,         32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{PC_OP_REG_JMP,   32'h0000_3004, 32'h0000_3004, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      exp_addr_q.push_back(tbl[i].nxt);
      retire(tbl[i].op, tbl[i].tgt);
      wait_req(ok);
      e = exp_addr_q.pop_front();
      checks++;
      if (!ok || imem_addr !== e) begin
        errors++;
        $display("[TB] FAIL jump%0d: req=%b addr=%h, expected %h", i, imem_req, imem_addr, e);
      end
      respond(tbl[i].data);
    end
    retire(PC_OP_REG_JMP, 32'h0000_3006);
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h3004) begin
      errors++;
      $display("[TB] FAIL misaligned_jmp: err=%b req=%b valid=%b pc=%h, expected err=1 req=0 valid=0 pc=00003004",
               fetch_err, imem_req, inst_valid, pc);
    end
    step();
    step();
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_hold: err=%b req=%b, expected err=1 req=0", fetch_err, imem_req);
    end
  endtask

  task automatic test_stall_race();
    logic [31:0] e;
    do_reset();
    step();
    exp_inst_q.push_back(32'h1234_5678);
    respond(32'h1234_5678);
    e = exp_inst_q.pop_front();
    stall       = 1'b1;
    inst_done   = 1'b1;
    pc_op       = PC_OP_NEXT_STEP;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h0 || inst !== e || imem_req !== 1'b0 || inst_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: pc=%h inst=%h req=%b valid=%b, expected pc=0 inst=%h req=0 valid=1",
                 i, pc, inst, imem_req, inst_valid, e);
      end
    end
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    stall       = 1'b0;
    exp_addr_q.push_back(32'h4);
    step();
    inst_done = 1'b0;
    e = exp_addr_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== e) begin
      errors++;
      $display("[TB] FAIL stall_release: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, e);
    end
  endtask

  task automatic test_timeout();
    inst_done = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h4) begin
      errors++;
      $display("[TB] FAIL timeout_early: err=%b req=%b pc=%h after 15 cycles, expected err=0 req=1 pc=00000004",
               fetch_err, imem_req, pc);
    end
    step();
    inst_done = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_hit: err=%b req=%b after 16 cycles, expected err=1 req=0", fetch_err, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hABCD_0123;
    step();
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0 || inst === 32'hABCD_0123) begin
      errors++;
      $display("[TB] FAIL err_sticky: err=%b valid=%b req=%b inst=%h, expected err=1 valid=0 req=0 inst!=abcd0123",
               fetch_err, inst_valid, imem_req, inst);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] e;
    do_reset();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_abort: req=%b valid=%b err=%b pc=%h, expected 0/0/0/0", imem_req, inst_valid, fetch_err, pc);
    end
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    exp_addr_q.push_back(32'h0);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    e = exp_addr_q.pop_front();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== e || inst_valid !== 1'b0 || inst !== 32'h0) begin
      errors++;
      $display("[TB] FAIL boot_drop: req=%b addr=%h valid=%b inst=%h, expected req=1 addr=%h valid=0 inst=0",
               imem_req, imem_addr, inst_valid, inst, e);
    end
    exp_inst_q.push_back(32'h2008_0005);
    respond(32'h2008_0005);
    e = exp_inst_q.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== e || inst_op !== 6'h08) begin
      errors++;
      $display("[TB] FAIL refetch: valid=%b inst=%h op=%h, expected valid=1 inst=%h op=08", inst_valid, inst, inst_op, e);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    pc_op       = PC_OP_NEXT_STEP;
    reg_target  = '0;
    inst_done   = 1'b0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_jumps();
    test_stall_race();
    test_timeout();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
